// File: rtl/poly_eval_arbiter_pkg.sv
// Shared types and constants for the two-requester quadratic evaluator.
// Holds the FSM state encoding, the ALU op codes, the operand select codes and the default width.
package poly_eval_arbiter_pkg;

  localparam int POLY_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL0 = 3'd1;
  localparam logic [2:0] ST_ADD0 = 3'd2;
  localparam logic [2:0] ST_MUL1 = 3'd3;
  localparam logic [2:0] ST_ADD1 = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_MUL0 = ST_MUL0,
    S_ADD0 = ST_ADD0,
    S_MUL1 = ST_MUL1,
    S_ADD1 = ST_ADD1,
    S_RESP = ST_RESP
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_t;

  // Operand register indices, also used as the right-hand ALU source select.
  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_X = 2'd3;

endpackage

// File: rtl/poly_eval_arbiter_if.sv
// Request/response bundle between the requesters/consumer (master) and the evaluator (slave).
interface poly_eval_arbiter_if
  import poly_eval_arbiter_pkg::*;
#(
  parameter int W = POLY_W
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a, req0_b, req0_c, req0_x;
  logic [W-1:0] req1_a, req1_b, req1_c, req1_x;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         busy;

  modport master (
    output req_valid, req0_a, req0_b, req0_c, req0_x,
           req1_a, req1_b, req1_c, req1_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_c, req0_x,
           req1_a, req1_b, req1_c, req1_x, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/poly_eval_arbiter_datapath.sv
// Operand registers, accumulator and one-operator ALU used for the Horner steps.
// Each step truncates to W bits, so the final value is exact modulo 2^W.
module horner_datapath
  import poly_eval_arbiter_pkg::*;
#(
  parameter int W = POLY_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld_ops,
  input  logic [3:0][W-1:0]  in_ops,
  input  logic [1:0]         src_sel,
  input  alu_op_t            op,
  input  logic               ld_acc,
  input  logic               ld_first,
  output logic [W-1:0]       acc
);
  logic [3:0][W-1:0] ops;
  logic [W-1:0]      acc_reg;
  logic [W-1:0]      acc_next;
  logic [W-1:0]      lhs;
  logic [W-1:0]      rhs;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ops
      logic [W-1:0] q_reg;
      always_ff @(posedge clk) begin
        if (!resetn) begin
          q_reg <= '0;
        end else if (ld_ops) begin
          q_reg <= in_ops[gi];
        end
      end
      assign ops[gi] = q_reg;
    end
  endgenerate

  // The first multiply starts from operand a rather than the accumulator.
  assign lhs      = ld_first ? ops[SRC_A] : acc_reg;
  assign rhs      = ops[src_sel];
  assign acc_next = (op == OP_MUL) ? lhs * rhs : lhs + rhs;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_reg <= '0;
    end else if (ld_acc) begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/poly_eval_arbiter.sv
// Round-robin front end and step sequencer for y = A*x^2 + B*x + C on one shared ALU.
// Accepts one request in IDLE, runs four Horner steps, then holds the result until taken.
module poly_eval_arbiter
  import poly_eval_arbiter_pkg::*;
#(
  parameter int W = POLY_W
) (
  input  logic               clk,
  input  logic               resetn,
  poly_eval_arbiter_if.slave bus
);
  state_t            state_reg;
  logic              last_grant_reg;
  logic              id_reg;
  logic              rsp_valid_reg;
  logic              busy_reg;
  logic              grant;
  logic              accept;
  logic              ld_acc;
  logic              ld_first;
  logic [1:0]        src_sel;
  alu_op_t           op;
  logic [3:0][W-1:0] req_ops;
  logic [W-1:0]      acc;

  // A lone requester always wins; a tie goes to whoever did not win last.
  always_comb begin
    grant = bus.req_valid[1];
    if (&bus.req_valid) begin
      grant = ~last_grant_reg;
    end
  end

  assign accept = (state_reg == S_IDLE) && (|bus.req_valid);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign bus.req_ready[gi] = accept && (grant == 1'(gi));
    end
  endgenerate

  assign req_ops[SRC_A] = grant ? bus.req1_a : bus.req0_a;
  assign req_ops[SRC_B] = grant ? bus.req1_b : bus.req0_b;
  assign req_ops[SRC_C] = grant ? bus.req1_c : bus.req0_c;
  assign req_ops[SRC_X] = grant ? bus.req1_x : bus.req0_x;

  always_comb begin
    ld_acc   = 1'b0;
    ld_first = 1'b0;
    src_sel  = SRC_X;
    op       = OP_ADD;
    case (state_reg)
      S_MUL0: begin ld_acc = 1'b1; ld_first = 1'b1; op = OP_MUL; end
      S_ADD0: begin ld_acc = 1'b1; src_sel = SRC_B; end
      S_MUL1: begin ld_acc = 1'b1; op = OP_MUL; end
      S_ADD1: begin ld_acc = 1'b1; src_sel = SRC_C; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg      <= S_MUL0;
            id_reg         <= grant;
            last_grant_reg <= grant;
            busy_reg       <= 1'b1;
          end
        end
        S_MUL0: state_reg <= S_ADD0;
        S_ADD0: state_reg <= S_MUL1;
        S_MUL1: state_reg <= S_ADD1;
        S_ADD1: begin
          state_reg     <= S_RESP;
          rsp_valid_reg <= 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= S_IDLE;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  horner_datapath #(.W(W)) u_datapath (
    .clk      (clk),
    .resetn   (resetn),
    .ld_ops   (accept),
    .in_ops   (req_ops),
    .src_sel  (src_sel),
    .op       (op),
    .ld_acc   (ld_acc),
    .ld_first (ld_first),
    .acc      (acc)
  );

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_data  = acc;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Directed bench for poly_eval_arbiter: vector table of single requests plus
// hand-written tie, backpressure, operand-change and mid-operation reset sequences.
module tb_poly_eval_arbiter;
  import poly_eval_arbiter_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  poly_eval_arbiter_if #(.W(W)) bus ();

  poly_eval_arbiter #(.W(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         r;
    logic [7:0] a, b, c, x;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input bit r, input logic [7:0] a, b, c, x);
    if (r) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_c = c; bus.req1_x = x;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_c = c; bus.req0_x = x;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    resetn = 1'b1;
  endtask

  // One request from requester r with rsp_ready high; checks grant, latency and result.
  task automatic run_txn(input bit r, input logic [7:0] a, b, c, x, exp,
                         input bit mutate, input string tag);
    int waitc;
    int lat;
    @(negedge clk);
    set_ops(r, a, b, c, x);
    bus.req_valid = 2'b01 << r;
    #1;
    waitc = 0;
    while (bus.req_ready == 2'b00 && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    chk({tag, "_ready"}, bus.req_ready, 2'b01 << r);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.req_valid = 2'b00;
        if (mutate) set_ops(r, ~a, ~b, ~c, ~x);
      end
    end while (!bus.rsp_valid && lat < 20);
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_data"}, bus.rsp_data, exp);
    chk({tag, "_id"}, bus.rsp_id, r);
    chk({tag, "_busy"}, bus.busy, 1'b1);
    $display("txn %s req=%0d a=%0d b=%0d c=%0d x=%0d -> data=0x%02h id=%0d lat=%0d", tag,
             r, a, b, c, x, bus.rsp_data, bus.rsp_id, lat);
    @(negedge clk);
    chk({tag, "_done_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_done_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tie;
    bit         grants[$];
    bit         ids[$];
    logic [7:0] datas[$];
    int         lat;
    bit         saw_valid;

    vecs[0] = '{r: 1'b0, a: 8'd2,  b: 8'd3, c: 8'd4, x: 8'd5,   exp: 8'h45};
    vecs[1] = '{r: 1'b1, a: 8'd1,  b: 8'd1, c: 8'd1, x: 8'd255, exp: 8'h01};
    vecs[2] = '{r: 1'b0, a: 8'd16, b: 8'd0, c: 8'd1, x: 8'd16,  exp: 8'h01};
    vecs[3] = '{r: 1'b1, a: 8'd3,  b: 8'd7, c: 8'd9, x: 8'd10,  exp: 8'h7B};

    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    set_ops(0, 0, 0, 0, 0);
    set_ops(1, 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].x, vecs[i].exp, 1'b0,
              $sformatf("vec%0d", i));
    end

    run_txn(1'b0, 8'd2, 8'd3, 8'd4, 8'd5, 8'h45, 1'b1, "mutate");

    // Tie: both requesters valid continuously from reset.
    do_reset();
    set_ops(0, 8'd2, 8'd3, 8'd4, 8'd5);
    set_ops(1, 8'd1, 8'd1, 8'd1, 8'd255);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 2'b11;
      #1;
      chk("tie_onehot", ($countones(bus.req_ready) <= 1), 1'b1);
      if (bus.req_ready != 2'b00) grants.push_back(bus.req_ready[1]);
      if (bus.rsp_valid) begin
        ids.push_back(bus.rsp_id);
        datas.push_back(bus.rsp_data);
        $display("txn tie id=%0d data=0x%02h", bus.rsp_id, bus.rsp_data);
      end
    end
    bus.req_valid = 2'b00;
    chk("tie_grant_count", grants.size(), 4);
    chk("tie_rsp_count", ids.size(), 4);
    for (int k = 0; k < 4; k++) begin
      exp_tie = (k % 2 == 1) ? 8'h01 : 8'h45;
      if (k < grants.size()) chk($sformatf("tie_grant%0d", k), grants[k], k % 2);
      if (k < ids.size()) begin
        chk($sformatf("tie_id%0d", k), ids[k], k % 2);
        chk($sformatf("tie_data%0d", k), datas[k], exp_tie);
      end
    end

    // Backpressure: response held 10 cycles with another request pending.
    do_reset();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    set_ops(1, 8'd3, 8'd7, 8'd9, 8'd10);
    bus.req_valid = 2'b10;
    #1;
    chk("bp_ready", bus.req_ready, 2'b10);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.req_valid = 2'b00;
    end while (!bus.rsp_valid && lat < 20);
    chk("bp_latency", lat, 5);
    set_ops(0, 8'd2, 8'd3, 8'd4, 8'd5);
    bus.req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_data", bus.rsp_data, 8'h7B);
      chk("bp_id", bus.rsp_id, 1'b1);
      chk("bp_req_ready", bus.req_ready, 2'b00);
      chk("bp_busy", bus.busy, 1'b1);
    end
    $display("txn backpressure id=%0d data=0x%02h", bus.rsp_id, bus.rsp_data);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_hs_req_ready", bus.req_ready, 2'b00);
    chk("bp_hs_valid", bus.rsp_valid, 1'b1);
    @(negedge clk);
    #1;
    chk("bp_idle_busy", bus.busy, 1'b0);
    chk("bp_idle_valid", bus.rsp_valid, 1'b0);
    chk("bp_idle_req_ready", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;

    // Reset during MUL1 discards the request.
    @(negedge clk);
    set_ops(1, 8'd5, 8'd6, 8'd7, 8'd8);
    bus.req_valid = 2'b10;
    #1;
    chk("mid_ready", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_ready", bus.req_ready, 2'b00);
    chk("mid_rst_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_id", bus.rsp_id, 1'b0);
    chk("mid_rst_data", bus.rsp_data, 8'h00);
    chk("mid_rst_busy", bus.busy, 1'b0);
    resetn = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_valid = 1'b1;
    end
    chk("mid_no_rsp", saw_valid, 1'b0);
    $display("txn reset_mid_op discarded");
    run_txn(1'b0, 8'd0, 8'd0, 8'd7, 8'd9, 8'h07, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_eval_arbiter.md
# poly_eval_arbiter

Shared-datapath scheduler for quadratic evaluation y = A·x² + B·x + C, mod 2^W. Two requesters submit operand sets over valid/ready handshakes. The block arbitrates round-robin, captures the winner's operands, and sequences a single multiply/add ALU through four Horner steps. It then returns the result with the requester ID over a valid/ready response channel. It replaces push-button sequencing of the polynomial datapath, so streaming logic can share one ALU.

## Interface
- W, 8, operand/result width; all arithmetic is modulo 2^W.
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high in any cycle.
- req0_a, req0_b, req0_c, req0_x  in  W each  requester 0 operands.
- req1_a, req1_b, req1_c, req1_x  in  W each  requester 1 operands.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns rsp_data.
- rsp_data  out  W  result.
- busy  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE → MUL0 → ADD0 → MUL1 → ADD1 → RESP → IDLE.
- **IDLE**
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise grant g is the valid requester. If both are valid, g = ~last_grant.
  - Drive req_ready[g]=1 combinationally. The transfer happens in this cycle.
  - On the transfer: latch a, b, c, x from requester g, set id=g, set last_grant=g, go to MUL0.
- **MUL0:** acc ← a·x.
- **ADD0:** acc ← acc + b.
- **MUL1:** acc ← acc·x.
- **ADD1:** acc ← acc + c, then go to RESP.
- **Width rule:** each step truncates to W bits. The result equals the exact value mod 2^W.
- **RESP**
  - rsp_valid=1, rsp_data=acc, rsp_id=id.
  - Stay in RESP while rsp_ready=0. On rsp_valid & rsp_ready, go to IDLE.
- **Outputs outside accept/response:** req_ready=00 in all states except IDLE, and also in IDLE when no request is valid.
- **Round-robin:** last_grant updates only on a transfer. A lone requester is always granted, whatever last_grant holds.
- **Requester changes after the transfer:** changes to the requester's operands or valid are ignored until the next IDLE.

## Timing
- **Reset values:** state=IDLE, last_grant=1 (so requester 0 wins the first tie), acc=0, id=0. Outputs: req_ready=00, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- **Reset mid-operation:** the in-flight request is discarded and no response is issued. The next cycle behaves as post-reset IDLE.
- **Latency:** request transfer at cycle N → rsp_valid first high at cycle N+5.
- **Throughput:** at most one request per 6 cycles with rsp_ready tied high.
- **Response stability:** rsp_data and rsp_id are stable from rsp_valid rise until the handshake.
- **No early accept:** a request is never accepted in the same cycle as a response handshake. The next accept is no earlier than the following cycle, in IDLE.
- **Ready path:** req_ready depends only on state, last_grant and req_valid, never on operand values.

## Structure
- **Shared package:** state encoding localparams (IDLE..RESP, 3 bits), ALU op codes (OP_ADD, OP_MUL), and the default W.
- **Sub-module `horner_datapath`:** holds the operand registers, acc, the operand-select mux and the one-operator ALU. It takes controls ld_ops, src_sel[1:0] (a/b/c/x), op, ld_acc and ld_first.
  - ld_first selects operand a instead of acc as the left ALU input in MUL0.
  - The top level keeps the FSM, arbiter and handshakes.

## Test plan
- **Single request:** req0 A=2, B=3, C=4, x=5 → rsp_valid 5 cycles after accept, rsp_data=0x45, rsp_id=0.
- **Overflow:** req1 A=1, B=1, C=1, x=255 → rsp_data=0x01, rsp_id=1. Also A=16, B=0, C=1, x=16 → 0x01.
- **Tie and fairness:** both valid continuously after reset → grants in order 0,1,0,1; req_ready never 11; four correct responses with alternating rsp_id.
- **Backpressure:** hold rsp_ready=0 for 10 cycles → rsp_valid stays 1, rsp_data/rsp_id unchanged, req_ready=00, busy=1. Raise rsp_ready → IDLE next cycle.
- **Operand change after accept:** change req0 operands in the cycle after accept → result reflects the latched operands only.
- **Reset mid-operation:** assert resetn=0 during MUL1 → all outputs take reset values, no rsp_valid. The next request (A=0, B=0, C=7, x=9) returns 0x07 with rsp_id=0.
